// File: rtl/address_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : address_generator_if
// Purpose  : Bus bundle between the layer controller and the address
//            generator. It carries the configuration in and the RAM
//            addresses and completion flag out.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Signals
//   read                   ctrl -> gen  1 = load/hold config, 0 = run
//   Nk                     ctrl -> gen  neurons per layer
//   read_weight_base_addr  ctrl -> gen  weight matrix base (row-major)
//   read_neuro_base_addr   ctrl -> gen  input neuron vector base
//   write_neuro_base_addr  ctrl -> gen  output neuron vector base
//   finished               gen -> ctrl  layer complete
//   weight_read_addr       gen -> RAM   current weight address
//   neuro_read_addr        gen -> RAM   current input-neuron address
//   neuro_write_addr       gen -> RAM   current output-neuron address
// ============================================================================
interface address_generator_if #(
    parameter int AW = 8
);
    logic          read;
    logic [AW-1:0] Nk;
    logic [AW-1:0] read_weight_base_addr;
    logic [AW-1:0] read_neuro_base_addr;
    logic [AW-1:0] write_neuro_base_addr;
    logic          finished;
    logic [AW-1:0] weight_read_addr;
    logic [AW-1:0] neuro_read_addr;
    logic [AW-1:0] neuro_write_addr;

    // Controller side
    modport master (
        output read, Nk, read_weight_base_addr, read_neuro_base_addr,
               write_neuro_base_addr,
        input  finished, weight_read_addr, neuro_read_addr, neuro_write_addr
    );

    // Address generator side
    modport slave (
        input  read, Nk, read_weight_base_addr, read_neuro_base_addr,
               write_neuro_base_addr,
        output finished, weight_read_addr, neuro_read_addr, neuro_write_addr
    );
endinterface
`default_nettype wire

// File: rtl/address_generator.sv
`default_nettype none
// ============================================================================
// Module   : address_generator
// Purpose  : Address sequencer for one fully connected NN layer (Nk inputs,
//            Nk outputs). Per output neuron it emits Nk read cycles (weight
//            and input-neuron address) followed by one write cycle for the
//            neuron result, then raises finished.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   bus    slave modport of address_generator_if (config in, addresses out)
// Build option
//   ADDRGEN_AUTORESTART_EN  when defined, DONE with read = 0 lasts a single
//                           cycle and the layer restarts with the latched
//                           configuration. Otherwise DONE is terminal until
//                           read = 1 or reset.
// ============================================================================
module address_generator #(
    parameter int AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    address_generator_if.slave bus
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] C_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] C_ZERO = '0;

    state_t        state_q;
    logic [AW-1:0] nk_q;
    logic [AW-1:0] wb_q;
    logic [AW-1:0] nb_q;
    logic [AW-1:0] ob_q;
    logic [AW-1:0] i_q;
    logic [AW-1:0] j_q;
    logic [AW-1:0] woff_q;

    // nk_q is never 0 while in RUN/WRITE, so the subtraction cannot underflow there.
    logic w_last_i;
    logic w_last_j;
    assign w_last_i = (i_q == (nk_q - C_ONE));
    assign w_last_j = (j_q == (nk_q - C_ONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            nk_q    <= C_ZERO;
            wb_q    <= C_ZERO;
            nb_q    <= C_ZERO;
            ob_q    <= C_ZERO;
            i_q     <= C_ZERO;
            j_q     <= C_ZERO;
            woff_q  <= C_ZERO;
        end else if (bus.read) begin
            // read = 1 overrides every state: (re)capture the configuration.
            state_q <= LOAD;
            nk_q    <= bus.Nk;
            wb_q    <= bus.read_weight_base_addr;
            nb_q    <= bus.read_neuro_base_addr;
            ob_q    <= bus.write_neuro_base_addr;
            i_q     <= C_ZERO;
            j_q     <= C_ZERO;
            woff_q  <= C_ZERO;
        end else begin
            case (state_q)
                LOAD: begin
                    i_q     <= C_ZERO;
                    j_q     <= C_ZERO;
                    woff_q  <= C_ZERO;
                    state_q <= (nk_q == C_ZERO) ? DONE : RUN;
                end
                RUN: begin
                    if (w_last_i) begin
                        state_q <= WRITE;
                    end else begin
                        i_q    <= i_q + C_ONE;
                        woff_q <= woff_q + C_ONE;
                    end
                end
                WRITE: begin
                    if (w_last_j) begin
                        state_q <= DONE;
                    end else begin
                        // The weight offset keeps running: rows are contiguous.
                        j_q     <= j_q + C_ONE;
                        i_q     <= C_ZERO;
                        woff_q  <= woff_q + C_ONE;
                        state_q <= RUN;
                    end
                end
                DONE: begin
`ifdef ADDRGEN_AUTORESTART_EN
                    i_q     <= C_ZERO;
                    j_q     <= C_ZERO;
                    woff_q  <= C_ZERO;
                    state_q <= (nk_q == C_ZERO) ? DONE : RUN;
`else
                    state_q <= DONE;
`endif
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    // Outputs depend on registers only; no input reaches them combinationally.
    assign bus.weight_read_addr = wb_q + woff_q;
    assign bus.neuro_read_addr  = nb_q + i_q;
    assign bus.neuro_write_addr = ob_q + j_q;
    assign bus.finished         = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_address_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_address_generator
// Purpose  : Directed self-checking bench for address_generator.
// Revision : 1.0  initial release
// ============================================================================
module tb_address_generator;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    address_generator_if #(.AW(8)) bus ();

    address_generator #(.AW(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [7:0] nk, input logic [7:0] wb,
                            input logic [7:0] nb, input logic [7:0] ob);
        bus.read                  = 1'b1;
        bus.Nk                    = nk;
        bus.read_weight_base_addr = wb;
        bus.read_neuro_base_addr  = nb;
        bus.write_neuro_base_addr = ob;
        tick();
    endtask

    // Drop read and walk the whole layer, checking each cycle against the
    // closed-form address pattern; ends on the edge where finished rises.
    task automatic run_layer(input int nk, input logic [7:0] wb,
                             input logic [7:0] nb, input logic [7:0] ob);
        logic [7:0] e;
        bus.read = 1'b0;
        for (int n = 0; n < nk; n++) begin
            for (int i = 0; i < nk; i++) begin
                tick();
                e = wb + 8'(n * nk + i);
                check("run_weight", {24'd0, bus.weight_read_addr}, {24'd0, e});
                e = nb + 8'(i);
                check("run_neuro", {24'd0, bus.neuro_read_addr}, {24'd0, e});
                check("run_fin", {31'd0, bus.finished}, 32'd0);
            end
            tick();
            e = ob + 8'(n);
            check("write_addr", {24'd0, bus.neuro_write_addr}, {24'd0, e});
            check("write_fin", {31'd0, bus.finished}, 32'd0);
        end
        tick();
        check("done_fin", {31'd0, bus.finished}, 32'd1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        bus.read = 1'b1;
        bus.Nk = 8'd3;
        bus.read_weight_base_addr = 8'd1;
        bus.read_neuro_base_addr  = 8'd2;
        bus.write_neuro_base_addr = 8'd3;

        // Reset state
        #3;
        check("rst_weight", {24'd0, bus.weight_read_addr}, 32'd0);
        check("rst_nread", {24'd0, bus.neuro_read_addr}, 32'd0);
        check("rst_nwrite", {24'd0, bus.neuro_write_addr}, 32'd0);
        check("rst_fin", {31'd0, bus.finished}, 32'd0);
        #4 reset = 1'b1;

        // Config tracking in LOAD: Nk 3 then 4, the last value wins
        load_cfg(8'd3, 8'd1, 8'd2, 8'd3);
        check("load_weight", {24'd0, bus.weight_read_addr}, 32'd1);
        check("load_fin", {31'd0, bus.finished}, 32'd0);
        load_cfg(8'd4, 8'd1, 8'd2, 8'd3);

        // Nominal layer Nk = 4: 20 RUN/WRITE cycles, finished on edge 21
        run_layer(4, 8'd1, 8'd2, 8'd3);
`ifdef ADDRGEN_AUTORESTART_EN
        tick();
        check("auto_fin_pulse", {31'd0, bus.finished}, 32'd0);
        check("auto_restart_w", {24'd0, bus.weight_read_addr}, 32'd1);
`else
        tick();
        tick();
        check("done_hold_fin", {31'd0, bus.finished}, 32'd1);
        check("done_hold_w", {24'd0, bus.weight_read_addr}, 32'd16);
        check("done_hold_wr", {24'd0, bus.neuro_write_addr}, 32'd6);
`endif

        // read = 1 from DONE/RUN returns to LOAD
        load_cfg(8'd0, 8'd1, 8'd2, 8'd3);
        check("reload_fin", {31'd0, bus.finished}, 32'd0);
        // Nk = 0: finished on the first edge
        run_layer(0, 8'd1, 8'd2, 8'd3);

        // Nk = 1: RUN, WRITE, DONE
        load_cfg(8'd1, 8'd1, 8'd2, 8'd3);
        run_layer(1, 8'd1, 8'd2, 8'd3);

        // Abort mid-RUN
        load_cfg(8'd4, 8'd1, 8'd2, 8'd3);
        bus.read = 1'b0;
        tick();
        tick();
        check("pre_abort_w", {24'd0, bus.weight_read_addr}, 32'd2);
        bus.read = 1'b1;
        tick();
        check("abort_fin", {31'd0, bus.finished}, 32'd0);
        check("abort_w", {24'd0, bus.weight_read_addr}, 32'd1);
        tick();
        check("abort_hold_w", {24'd0, bus.weight_read_addr}, 32'd1);

        // Wrap: weight base 250, Nk = 4 -> 250..255,0..9
        load_cfg(8'd4, 8'd250, 8'd254, 8'd254);
        run_layer(4, 8'd250, 8'd254, 8'd254);

        // Asynchronous reset mid-operation
        load_cfg(8'd4, 8'd10, 8'd20, 8'd30);
        bus.read = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_w", {24'd0, bus.weight_read_addr}, 32'd12);
        #1 reset = 1'b0;
        #1;
        check("arst_weight", {24'd0, bus.weight_read_addr}, 32'd0);
        check("arst_nread", {24'd0, bus.neuro_read_addr}, 32'd0);
        check("arst_nwrite", {24'd0, bus.neuro_write_addr}, 32'd0);
        check("arst_fin", {31'd0, bus.finished}, 32'd0);
        bus.read = 1'b1;
        #1 reset = 1'b1;
        tick();
        check("post_rst_w", {24'd0, bus.weight_read_addr}, 32'd10);
        check("post_rst_fin", {31'd0, bus.finished}, 32'd0);
        tick();
        check("post_rst_hold", {24'd0, bus.neuro_read_addr}, 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/address_generator.md
Name: address_generator

Overview:
- Sequencer for one fully connected neural-network layer with Nk inputs and Nk outputs.
- Produces the memory addresses for each multiply-accumulate: one weight address and one input-neuron address per cycle.
- After each output neuron's Nk products, it issues one write cycle for that neuron's result.
- Sits between the layer controller, which supplies base addresses and Nk, and the weight/neuron RAMs; `finished` tells the controller the layer is complete.

Parameters:
- AW, 8, address and Nk width; all address arithmetic is modulo 2^AW.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- read  in  1  1 = load/hold configuration; 0 = run the layer sequence
- Nk  in  AW  neurons per layer (inputs = outputs = Nk)
- read_weight_base_addr  in  AW  base of the Nk*Nk weight matrix, row-major by output neuron
- read_neuro_base_addr  in  AW  base of the input neuron vector
- write_neuro_base_addr  in  AW  base of the output neuron vector
- finished  out  1  high while the layer sequence is complete
- weight_read_addr  out  AW  current weight address
- neuro_read_addr  out  AW  current input-neuron address
- neuro_write_addr  out  AW  current output-neuron address

Behaviour:
- Internal registers: nk_r, wb_r, nb_r, ob_r, i (input index), j (output index), woff (running weight offset).
- States: LOAD, RUN, WRITE, DONE.
- Outputs are pure functions of registers, with no combinational input-to-output path:
  - weight_read_addr = wb_r + woff
  - neuro_read_addr = nb_r + i
  - neuro_write_addr = ob_r + j
  - finished = (state == DONE)
- reset low (async): state = LOAD; all registers = 0; all outputs = 0; finished = 0.
- LOAD, read = 1:
  - Every edge captures Nk and the three bases into the *_r registers; i = j = woff = 0.
  - Stays in LOAD.
  - Later changes to Nk or the bases while read = 1 are tracked; the last value before read falls wins.
- LOAD, read = 0:
  - Next edge goes to RUN with i = j = woff = 0.
  - If nk_r == 0, go to DONE instead.
  - Inputs are not sampled again until the next LOAD.
- RUN (one weight/neuron read per cycle):
  - If i < nk_r-1: i++, woff++.
  - If i == nk_r-1: go to WRITE; i and woff hold.
- WRITE (one cycle; neuro_write_addr = ob_r + j is the valid write target):
  - If j < nk_r-1: j++, i = 0, woff++, back to RUN.
  - If j == nk_r-1: go to DONE.
- DONE: addresses hold their last values; finished = 1.
- read = 1 in any state: abort and go to LOAD at the next edge (finished drops, configuration recaptured).
- Total length for Nk = N ≥ 1: N*(N+1) cycles in RUN/WRITE. finished rises on the (N*(N+1)+1)-th rising edge after the first edge that samples read = 0.
- Address sums wrap modulo 256 with no flag. Nk = 1 gives RUN, WRITE, DONE. Nk = 255 is legal (woff wraps).

Optional Feature:
- Macro: ADDRGEN_AUTORESTART_EN.
- Defined: in DONE with read = 0, finished pulses high for exactly one cycle. The next edge restarts RUN with i = j = woff = 0, reusing the latched configuration (continuous inference).
- Undefined: DONE is terminal until read = 1 or reset.

Test Plan:
- Reset: assert reset = 0 mid-operation -> all outputs 0 and finished = 0 immediately; after release with read = 1 the block stays in LOAD.
- Config change in LOAD: read = 1, Nk = 3 then Nk = 4 with bases 1/2/3, then read = 0 -> the layer runs with Nk = 4.
- Nominal layer, Nk = 4, bases 1/2/3:
  - weight_read_addr steps 1..16 across the read cycles.
  - neuro_read_addr cycles 2,3,4,5 per output neuron.
  - neuro_write_addr is 3,4,5,6 in the four WRITE cycles.
  - finished rises on the 21st edge after read falls and stays high.
- Edge sizes: Nk = 0 -> finished on the 1st edge. Nk = 1 -> weight 1 / neuro 2, write 3, finished on the 3rd edge.
- Abort and wrap:
  - read = 1 mid-RUN -> LOAD next edge, finished = 0.
  - Base 250 with Nk = 4 -> weight_read_addr wraps 255 → 0 → 1 ....
- Autorestart (macro defined): finished is a 1-cycle pulse, then the sequence repeats from weight_read_addr = 1.
